// File: rtl/branch_cond_unit.sv
// Branch condition unit: ALU status register plus a three-stage branch resolver (IDLE/EVAL/RESP).
// Optional taken-branch counter output taken_cnt when BRANCH_CNT_EN is defined.
module branch_cond_unit #(
  parameter int PC_W  = 9,
  parameter int IMM_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_status,
  input  logic [2:0]       Z_in,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [1:0]       br_op,
  input  logic [2:0]       cond,
  input  logic [IMM_W-1:0] imm,
  input  logic [PC_W-1:0]  pc_cur,
  input  logic [15:0]      rd_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [PC_W-1:0]  pc_next,
  output logic             link_we,
  output logic [15:0]      link_val,
`ifdef BRANCH_CNT_EN
  output logic [15:0]      taken_cnt,
`endif
  output logic [2:0]       status_out
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  localparam logic [1:0] OP_B   = 2'b00;
  localparam logic [1:0] OP_BL  = 2'b01;
  localparam logic [1:0] OP_BX  = 2'b10;

  state_t            state, state_nx;
  logic [2:0]        status;
  logic [1:0]        op_q;
  logic [2:0]        cond_q;
  logic [IMM_W-1:0]  imm_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   rd_q;
  logic              taken_q;
  logic [PC_W-1:0]   pc_next_q;
  logic              link_q;
  logic [PC_W-1:0]   link_pc_q;

  logic              cond_true;
  logic [PC_W-1:0]   pc_seq;
  logic [PC_W-1:0]   pc_rel;
  logic              eval_taken;
  logic [PC_W-1:0]   eval_pc;
  logic              eval_link;
  logic              unused_rd_hi;

  assign unused_rd_hi = ^rd_val[15:PC_W];

  // Status bits: [0]=zero, [1]=negative, [2]=overflow.
  always_comb begin
    cond_true = 1'b0;
    case (cond_q)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = status[0];
      3'b010:  cond_true = ~status[0];
      3'b011:  cond_true = status[1] ^ status[2];
      3'b100:  cond_true = (status[1] ^ status[2]) | status[0];
      default: cond_true = 1'b0;
    endcase
  end

  assign pc_seq = pc_q + 1'b1;
  assign pc_rel = pc_seq + PC_W'($signed(imm_q));

  always_comb begin
    eval_taken = 1'b1;
    eval_pc    = rd_q;
    eval_link  = op_q[0];
    case (op_q)
      OP_B: begin
        eval_taken = cond_true;
        eval_pc    = cond_true ? pc_rel : pc_seq;
      end
      OP_BL:   eval_pc = pc_rel;
      default: eval_pc = rd_q;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (br_valid) state_nx = EVAL;
      EVAL:    state_nx = RESP;
      RESP:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      status    <= 3'b000;
      op_q      <= OP_B;
      cond_q    <= 3'b000;
      imm_q     <= '0;
      pc_q      <= '0;
      rd_q      <= '0;
      taken_q   <= 1'b0;
      pc_next_q <= '0;
      link_q    <= 1'b0;
      link_pc_q <= '0;
    end else begin
      state <= state_nx;
      if (load_status) status <= Z_in;
      if (state == IDLE && br_valid) begin
        op_q   <= br_op;
        cond_q <= cond;
        imm_q  <= imm;
        pc_q   <= pc_cur;
        rd_q   <= rd_val[PC_W-1:0];
      end
      if (state == EVAL) begin
        taken_q   <= eval_taken;
        pc_next_q <= eval_pc;
        link_q    <= eval_link;
        link_pc_q <= pc_seq;
      end
    end
  end

`ifdef BRANCH_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= 16'h0000;
    else if (state == RESP && out_ready && taken_q && cnt_q != 16'hFFFF)
      cnt_q <= cnt_q + 16'h0001;
  end
  assign taken_cnt = cnt_q;
`endif

  assign br_ready   = (state == IDLE);
  assign out_valid  = (state == RESP);
  assign taken      = taken_q;
  assign pc_next    = pc_next_q;
  assign link_we    = link_q & out_valid;
  assign link_val   = 16'(link_pc_q);
  assign status_out = status;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: directed vectors plus randomized branches against a behavioural model.
// Checks taken_cnt when BRANCH_CNT_EN is defined.
module tb_branch_cond_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_status = 1'b0;
  logic [2:0]  Z_in = 3'b000;
  logic        br_valid = 1'b0;
  logic        br_ready;
  logic [1:0]  br_op = 2'b00;
  logic [2:0]  cond = 3'b000;
  logic [7:0]  imm = 8'h00;
  logic [8:0]  pc_cur = 9'h000;
  logic [15:0] rd_val = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        taken;
  logic [8:0]  pc_next;
  logic        link_we;
  logic [15:0] link_val;
  logic [2:0]  status_out;
`ifdef BRANCH_CNT_EN
  logic [15:0] taken_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int st_m = 0;
  int cnt_m = 0;

  always #5 clk = ~clk;

  branch_cond_unit #(.PC_W(9), .IMM_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .load_status(load_status), .Z_in(Z_in),
    .br_valid(br_valid), .br_ready(br_ready), .br_op(br_op), .cond(cond),
    .imm(imm), .pc_cur(pc_cur), .rd_val(rd_val), .out_valid(out_valid),
    .out_ready(out_ready), .taken(taken), .pc_next(pc_next), .link_we(link_we),
    .link_val(link_val),
`ifdef BRANCH_CNT_EN
    .taken_cnt(taken_cnt),
`endif
    .status_out(status_out)
  );

  // Reference: condition truth from flags, then integer PC arithmetic mod 512.
  function automatic void model(input int op, input int cnd, input int im, input int pc,
                                input int rd, input int st, output int e_taken,
                                output int e_pc, output int e_lwe, output int e_lval);
    int z, n, v, c, off, target;
    z = st & 1;
    n = (st >> 1) & 1;
    v = (st >> 2) & 1;
    case (cnd)
      0: c = 1;
      1: c = z;
      2: c = (z == 0) ? 1 : 0;
      3: c = (n != v) ? 1 : 0;
      4: c = ((n != v) || (z == 1)) ? 1 : 0;
      default: c = 0;
    endcase
    off = (im >= 128) ? im - 256 : im;
    target = (pc + 1 + off + 512) % 512;
    e_lval = (pc + 1) % 512;
    case (op)
      0: begin e_taken = c; e_pc = c ? target : e_lval; e_lwe = 0; end
      1: begin e_taken = 1; e_pc = target; e_lwe = 1; end
      2: begin e_taken = 1; e_pc = rd % 512; e_lwe = 0; end
      default: begin e_taken = 1; e_pc = rd % 512; e_lwe = 1; end
    endcase
  endfunction

  task automatic set_status(input int z);
    load_status = 1'b1;
    Z_in = 3'(z);
    @(posedge clk); #1;
    load_status = 1'b0;
    st_m = z;
  endtask

  task automatic run_br(input string name, input int op, input int cnd, input int im,
                        input int pc, input int rd, input int hold,
                        input bit ld_acc, input int z_acc, input bit ld_eval,
                        input int z_eval, input bit keep_valid);
    int e_taken, e_pc, e_lwe, e_lval;
    br_op = 2'(op); cond = 3'(cnd); imm = 8'(im); pc_cur = 9'(pc); rd_val = 16'(rd);
    br_valid = 1'b1;
    if (ld_acc) begin load_status = 1'b1; Z_in = 3'(z_acc); end
    checks++;
    if (br_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle_ready: got %b want 1", name, br_ready);
    end
    @(posedge clk); #1;
    if (ld_acc) st_m = z_acc;
    load_status = 1'b0;
    model(op, cnd, im, pc, rd, st_m, e_taken, e_pc, e_lwe, e_lval);
    if (keep_valid) begin
      imm = 8'($urandom); pc_cur = 9'($urandom); rd_val = 16'($urandom);
      br_op = 2'($urandom); cond = 3'($urandom);
    end else br_valid = 1'b0;
    if (ld_eval) begin load_status = 1'b1; Z_in = 3'(z_eval); end
    checks++;
    if (out_valid !== 1'b0 || br_ready !== 1'b0) begin
      errors++; $display("FAIL %s eval: out_valid=%b br_ready=%b want 0 0", name, out_valid, br_ready);
    end
    @(posedge clk); #1;
    if (ld_eval) st_m = z_eval;
    load_status = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      checks++;
      if (out_valid !== 1'b1 || br_ready !== 1'b0 || taken !== 1'(e_taken) ||
          pc_next !== 9'(e_pc) || link_we !== 1'(e_lwe) || link_val !== 16'(e_lval) ||
          status_out !== 3'(st_m)) begin
        errors++;
        $display("FAIL %s resp[%0d]: got v=%b rdy=%b tk=%b pc=%h lwe=%b lv=%h st=%b want v=1 rdy=0 tk=%0d pc=%h lwe=%0d lv=%h st=%0d",
                 name, h, out_valid, br_ready, taken, pc_next, link_we, link_val, status_out,
                 e_taken, 9'(e_pc), e_lwe, 16'(e_lval), st_m);
      end
      if (h < hold) begin @(posedge clk); #1; end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    br_valid = 1'b0;
    if (e_taken == 1 && cnt_m < 65535) cnt_m++;
    checks++;
    if (out_valid !== 1'b0 || br_ready !== 1'b1 || link_we !== 1'b0) begin
      errors++; $display("FAIL %s done: v=%b rdy=%b lwe=%b want 0 1 0", name, out_valid, br_ready, link_we);
    end
`ifdef BRANCH_CNT_EN
    checks++;
    if (taken_cnt !== 16'(cnt_m)) begin
      errors++; $display("FAIL %s taken_cnt: got %0d want %0d", name, taken_cnt, cnt_m);
    end
`endif
    $display("txn %s op=%0d cond=%0d imm=%h pc=%h rd=%h st=%0d -> taken=%0d pc_next=%h link_we=%0d",
             name, op, cnd, im, pc, rd, st_m, e_taken, 9'(e_pc), e_lwe);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if (br_ready !== 1'b1 || out_valid !== 1'b0 || taken !== 1'b0 || pc_next !== 9'h0 ||
        link_we !== 1'b0 || link_val !== 16'h0 || status_out !== 3'b000) begin
      errors++;
      $display("FAIL reset: rdy=%b v=%b tk=%b pc=%h lwe=%b lv=%h st=%b want 1 0 0 0 0 0 0",
               br_ready, out_valid, taken, pc_next, link_we, link_val, status_out);
    end
`ifdef BRANCH_CNT_EN
    checks++;
    if (taken_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", taken_cnt);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    st_m = 0; cnt_m = 0;
  endtask

  task automatic test_spec_vectors();
    set_status(3'b001);
    run_br("beq", 0, 1, 8'h05, 10, 0, 0, 0, 0, 0, 0, 0);
    run_br("bne", 0, 2, 8'hFE, 10, 0, 0, 0, 0, 0, 0, 0);
    set_status(3'b010);
    run_br("blt", 0, 3, 8'hFC, 4, 0, 0, 0, 0, 0, 0, 0);
    run_br("ble", 0, 4, 8'hFC, 4, 0, 0, 0, 0, 0, 0, 0);
    set_status(3'b110);
    run_br("blt_nv", 0, 3, 8'hFC, 4, 0, 0, 0, 0, 0, 0, 0);
    run_br("blx_wrap", 3, 5, 8'h00, 9'h1FF, 16'h01F3, 0, 0, 0, 0, 0, 0);
    run_br("bl", 1, 6, 8'h80, 9'h010, 16'h0000, 0, 0, 0, 0, 0, 0);
    run_br("bx", 2, 0, 8'h7F, 9'h020, 16'hABCD, 0, 0, 0, 0, 0, 0);
    run_br("b_rsvd", 0, 7, 8'h10, 9'h050, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    run_br("hold5", 1, 0, 8'h22, 9'h0F0, 16'h0, 5, 0, 0, 0, 0, 0);
  endtask

  task automatic test_status_timing();
    set_status(3'b000);
    run_br("ld_acc_eval", 0, 1, 8'h05, 10, 0, 0, 1, 3'b001, 1, 3'b000, 0);
    checks++;
    if (status_out !== 3'b000) begin
      errors++; $display("FAIL status_after: got %b want 000", status_out);
    end
  endtask

  task automatic test_back_to_back();
    run_br("busy_hold", 0, 0, 8'h03, 9'h100, 0, 1, 0, 0, 0, 0, 1);
    run_br("b2b_1", 2, 0, 8'h00, 9'h000, 16'h0155, 0, 0, 0, 0, 0, 0);
    run_br("b2b_2", 0, 2, 8'hF0, 9'h005, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      set_status(int'($urandom_range(0, 7)));
      run_br("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 511)),
             int'($urandom_range(0, 65535)), int'($urandom_range(0, 2)),
             1'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
             int'($urandom_range(0, 7)), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_resp();
    set_status(3'b101);
    br_op = 2'b01; cond = 3'b000; imm = 8'h04; pc_cur = 9'h030; br_valid = 1'b1;
    @(posedge clk); #1;
    br_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL midresp_pre: out_valid=%b want 1", out_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || status_out !== 3'b000 || br_ready !== 1'b1 || link_we !== 1'b0) begin
      errors++;
      $display("FAIL midresp_reset: v=%b st=%b rdy=%b lwe=%b want 0 000 1 0",
               out_valid, status_out, br_ready, link_we);
    end
    @(negedge clk);
    reset_n = 1'b1;
    st_m = 0; cnt_m = 0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL midresp_after: out_valid=%b want 0", out_valid);
    end
    $display("txn reset_mid_resp dropped");
    run_br("post_reset", 0, 1, 8'h01, 9'h002, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_backpressure();
    test_status_timing();
    test_back_to_back();
    test_random();
    test_reset_mid_resp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
